// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
package mult_arb_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned PROD_W     = 2 * DATA_W_DEF;

  // Controller states, 2-bit encoding.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t RUN  = 2'd2;
  localparam state_t RESP = 2'd3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer hands priority to the
// other requester after every accepted grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       aclr_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // ptr_q == 0 gives req[0] priority on contention.
  logic ptr_q, ptr_d;

  // Grant: pointer owner on contention, otherwise whichever is requesting.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // Next pointer: move to the requester that did not win.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && (gnt != 2'b00)) begin
      ptr_d = gnt[0];
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one sequential multiplier between two valid/ready requesters, with a
// watchdog that aborts an operation whose done never arrives.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic                clk,
  input  logic                aclr_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DATA_W-1:0]   req0_a,
  input  logic [DATA_W-1:0]   req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DATA_W-1:0]   req1_a,
  input  logic [DATA_W-1:0]   req1_b,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [2*DATA_W-1:0] rsp_product,
  output logic                rsp_err,
  output logic                mul_start,
  output logic [DATA_W-1:0]   mul_data_a,
  output logic [DATA_W-1:0]   mul_data_b,
  input  logic                mul_done,
  input  logic [2*DATA_W-1:0] mul_product
);

  localparam int unsigned     PW     = 2 * DATA_W;
  localparam int unsigned     CNT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] WdLast = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] WdMax  = CNT_W'(TIMEOUT_CYC);

  state_t            state_q, state_d;
  logic              gnt_id_q, gnt_id_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  wd_q, wd_d;

  logic [1:0] arb_req;
  logic [1:0] gnt;
  logic       advance;
  logic       rsp_ack;

  // Requests only compete while idle; nothing is queued behind an op.
  assign arb_req = (state_q == IDLE) ? {req1_valid, req0_valid} : 2'b00;
  assign advance = (arb_req != 2'b00);

  rr_arb2 u_arb (
    .clk     (clk),
    .aclr_n  (aclr_n),
    .req     (arb_req),
    .advance (advance),
    .gnt     (gnt)
  );

  assign rsp_ack = gnt_id_q ? rsp1_ready : rsp0_ready;

  // Next-state logic for FSM, operand/result registers and watchdog.
  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    prod_d   = prod_q;
    err_d    = err_q;
    wd_d     = wd_q;
    unique case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          gnt_id_d = gnt[1];
          op_a_d   = gnt[1] ? req1_a : req0_a;
          op_b_d   = gnt[1] ? req1_b : req0_b;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        wd_d    = '0;
        state_d = RUN;
      end
      RUN: begin
        wd_d = (wd_q == WdMax) ? wd_q : wd_q + 1'b1;
        // wd_q == 0 marks the first RUN cycle, where done may be left over
        // from the previous operation.
        if ((wd_q != '0) && mul_done) begin
          prod_d  = mul_product;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_q == WdLast) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q  <= IDLE;
      gnt_id_q <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      prod_q   <= '0;
      err_q    <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      prod_q   <= prod_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
    end
  end

  assign req0_ready  = gnt[0];
  assign req1_ready  = gnt[1];
  assign mul_start   = (state_q == LOAD);
  assign mul_data_a  = op_a_q;
  assign mul_data_b  = op_b_q;
  assign rsp0_valid  = (state_q == RESP) && !gnt_id_q;
  assign rsp1_valid  = (state_q == RESP) && gnt_id_q;
  assign rsp_product = prod_q;
  assign rsp_err     = err_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomised self-checking bench for mult_arbiter with a behavioural multiplier.
module tb_mult_arbiter;

  localparam int T = 32;

  logic        clk = 1'b0;
  logic        aclr_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [15:0] rsp_product;
  logic        rsp_err;
  logic        mul_start;
  logic [7:0]  mul_data_a, mul_data_b;
  logic        mul_done = 1'b0;
  logic [15:0] mul_product = '0;

  int checks = 0;
  int passed = 0;

  mult_arbiter #(
    .DATA_W      (8),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk         (clk),
    .aclr_n      (aclr_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp_product (rsp_product),
    .rsp_err     (rsp_err),
    .mul_start   (mul_start),
    .mul_data_a  (mul_data_a),
    .mul_data_b  (mul_data_b),
    .mul_done    (mul_done),
    .mul_product (mul_product)
  );

  always #5 clk = ~clk;

  logic [37:0] all_out;
  assign all_out = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_product, rsp_err,
                    mul_start, mul_data_a, mul_data_b};

  // Behavioural multiplier: done is a level that stays up until the next start.
  // In stale mode the old done/product survive one extra cycle past start.
  int         m_lat = 5;
  bit         m_never = 1'b0;
  bit         m_stale_mode = 1'b0;
  logic [7:0] m_a = '0, m_b = '0;
  int         m_cnt = 0;
  bit         m_pend = 1'b0;
  bit         m_stale = 1'b0;

  always @(posedge clk) begin
    if (mul_start) begin
      m_a     <= mul_data_a;
      m_b     <= mul_data_b;
      m_cnt   <= m_lat;
      m_pend  <= 1'b1;
      m_stale <= m_stale_mode;
      if (!m_stale_mode) mul_done <= 1'b0;
    end else begin
      if (m_stale) begin
        m_stale  <= 1'b0;
        mul_done <= 1'b0;
      end
      if (m_pend) begin
        if (m_cnt <= 1) begin
          m_pend <= 1'b0;
          if (!m_never) begin
            mul_done    <= 1'b1;
            mul_product <= 16'(m_a) * 16'(m_b);
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // Reference model: round-robin pointer (0 = req0 has priority).
  int ptr = 0;

  function automatic int predict(input bit v0, input bit v1);
    if (v0 && v1) return ptr;
    return v1 ? 1 : 0;
  endfunction

  // Observations from the last transaction.
  int          o_win, o_ch, o_lat, o_starts, o_start_c;
  logic [15:0] o_prod;
  logic        o_err;
  bit          o_data_ok, o_quiet_ok, o_stable_ok;

  // Drives one request/response transaction and records what the DUT did.
  task automatic run_op(input bit v0, input bit v1, input logic [7:0] a0, input logic [7:0] b0,
                        input logic [7:0] a1, input logic [7:0] b1, input int lat,
                        input bit nodone, input bit stale, input int bp);
    logic [7:0] ea, eb;
    m_lat = lat; m_never = nodone; m_stale_mode = stale;
    o_win = -1; o_ch = -1; o_lat = -1; o_starts = 0; o_start_c = -1;
    o_prod = 'x; o_err = 1'bx;
    o_data_ok = 1'b1; o_quiet_ok = 1'b1; o_stable_ok = 1'b1;
    @(negedge clk);
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    #1;
    if (req0_ready && req1_ready) o_quiet_ok = 1'b0;
    if (req1_ready) o_win = 1;
    else if (req0_ready) o_win = 0;
    ea = (o_win == 1) ? a1 : a0;
    eb = (o_win == 1) ? b1 : b0;
    for (int c = 1; c <= T + 20; c++) begin
      @(negedge clk); #1;
      if (mul_start) begin
        o_starts++;
        if (o_start_c < 0) o_start_c = c;
      end
      if ((c >= 1) && (mul_data_a !== ea || mul_data_b !== eb) && o_lat < 0) o_data_ok = 1'b0;
      if (req0_ready || req1_ready) o_quiet_ok = 1'b0;
      if (rsp0_valid || rsp1_valid) begin
        o_lat = c;
        break;
      end
    end
    if (o_lat < 0) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    o_ch   = (rsp0_valid && rsp1_valid) ? 2 : (rsp1_valid ? 1 : 0);
    o_prod = rsp_product;
    o_err  = rsp_err;
    repeat (bp) begin
      @(negedge clk); #1;
      if (rsp_product !== o_prod || rsp_err !== o_err) o_stable_ok = 1'b0;
      if ((o_ch == 1) ? !rsp1_valid : !rsp0_valid) o_stable_ok = 1'b0;
      if (req0_ready || req1_ready) o_quiet_ok = 1'b0;
    end
    @(negedge clk);
    if (o_ch == 1) rsp1_ready = 1'b1;
    else rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    if (rsp0_valid || rsp1_valid) o_stable_ok = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    aclr_n = 1'b0;
    repeat (2) @(negedge clk);
    aclr_n = 1'b1;
    ptr = 0;
  endtask

  task automatic test_reset();
    aclr_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (all_out !== '0) $display("FAIL reset_outputs: got %h expected 0", all_out);
    else passed++;
    @(negedge clk);
    aclr_n = 1'b1;
    ptr = 0;
  endtask

  task automatic test_single_op();
    int ew;
    ew = predict(1'b1, 1'b0);
    run_op(1'b1, 1'b0, 8'd12, 8'd13, 8'd0, 8'd0, 5, 1'b0, 1'b0, 0);
    ptr = 1 - ew;
    checks++;
    if (o_win !== ew || o_ch !== ew) $display("FAIL single_grant: win %0d ch %0d expected %0d", o_win, o_ch, ew);
    else passed++;
    checks++;
    if (o_prod !== 16'd156 || o_err !== 1'b0) $display("FAIL single_product: got %0d err %b expected 156 err 0", o_prod, o_err);
    else passed++;
    checks++;
    if (o_starts !== 1 || o_start_c !== 1) $display("FAIL single_start: %0d pulses at cycle %0d expected 1 at 1", o_starts, o_start_c);
    else passed++;
    checks++;
    if (o_lat !== 8) $display("FAIL single_latency: got %0d expected 8", o_lat);
    else passed++;
    checks++;
    if (!o_data_ok || !o_quiet_ok) $display("FAIL single_operands: data_ok %b quiet_ok %b expected 1 1", o_data_ok, o_quiet_ok);
    else passed++;
  endtask

  task automatic test_contention();
    int ew;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ew = predict(1'b1, 1'b1);
      run_op(1'b1, 1'b1, 8'd3, 8'd4, 8'd5, 8'd6, 2 + i, 1'b0, 1'b0, 0);
      ptr = 1 - ew;
      checks++;
      if (o_win !== ew || o_ch !== ew) $display("FAIL contention_grant_%0d: win %0d ch %0d expected %0d", i, o_win, o_ch, ew);
      else passed++;
      checks++;
      if (o_prod !== ((ew == 1) ? 16'd30 : 16'd12)) $display("FAIL contention_product_%0d: got %0d expected %0d", i, o_prod, (ew == 1) ? 30 : 12);
      else passed++;
    end
  endtask

  task automatic test_stale_done();
    // Previous op left done high; stale mode keeps it up into the first RUN cycle.
    run_op(1'b1, 1'b1, 8'd7, 8'd9, 8'd7, 8'd9, 4, 1'b0, 1'b1, 0);
    ptr = 1 - o_win;
    checks++;
    if (o_prod !== 16'd63 || o_err !== 1'b0) $display("FAIL stale_product: got %0d err %b expected 63 err 0", o_prod, o_err);
    else passed++;
    checks++;
    if (o_lat !== 7) $display("FAIL stale_latency: got %0d expected 7", o_lat);
    else passed++;
  endtask

  task automatic test_timeout();
    int ew;
    ew = predict(1'b1, 1'b0);
    run_op(1'b1, 1'b0, 8'd9, 8'd9, 8'd0, 8'd0, 3, 1'b1, 1'b0, 2);
    ptr = 1 - ew;
    m_never = 1'b0;
    checks++;
    if (o_prod !== 16'd0 || o_err !== 1'b1) $display("FAIL timeout_result: got %0d err %b expected 0 err 1", o_prod, o_err);
    else passed++;
    checks++;
    if (o_lat !== T + 2) $display("FAIL timeout_latency: got %0d expected %0d", o_lat, T + 2);
    else passed++;
    checks++;
    if (!o_stable_ok || o_ch !== ew) $display("FAIL timeout_channel: stable %b ch %0d expected 1 %0d", o_stable_ok, o_ch, ew);
    else passed++;
  endtask

  task automatic test_back_pressure();
    int ew;
    if (ptr == 0) begin
      run_op(1'b1, 1'b0, 8'd2, 8'd2, 8'd0, 8'd0, 2, 1'b0, 1'b0, 0);
      ptr = 1;
    end
    ew = predict(1'b1, 1'b1);
    run_op(1'b1, 1'b1, 8'd11, 8'd3, 8'd17, 8'd19, 6, 1'b0, 1'b0, 10);
    ptr = 1 - ew;
    checks++;
    if (o_win !== 1 || o_ch !== 1) $display("FAIL bp_grant: win %0d ch %0d expected 1", o_win, o_ch);
    else passed++;
    checks++;
    if (o_prod !== 16'd323) $display("FAIL bp_product: got %0d expected 323", o_prod);
    else passed++;
    checks++;
    if (!o_stable_ok || !o_quiet_ok) $display("FAIL bp_stall: stable %b quiet %b expected 1 1", o_stable_ok, o_quiet_ok);
    else passed++;
  endtask

  task automatic test_extremes_reset();
    bit seen;
    run_op(1'b1, 1'b0, 8'd255, 8'd255, 8'd0, 8'd0, 3, 1'b0, 1'b0, 0);
    ptr = 1 - o_win;
    checks++;
    if (o_prod !== 16'hFE01 || o_err !== 1'b0) $display("FAIL max_product: got %h err %b expected fe01 err 0", o_prod, o_err);
    else passed++;
    // Start a req0 op that never completes, then reset it during RUN.
    m_never = 1'b1;
    @(negedge clk);
    req0_a = 8'd200; req0_b = 8'd100; req0_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    aclr_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) $display("FAIL midrun_reset_outputs: got %h expected 0", all_out);
    else passed++;
    @(negedge clk);
    aclr_n = 1'b1;
    ptr = 0;
    seen = 1'b0;
    for (int i = 0; i < T + 5; i++) begin
      @(negedge clk); #1;
      if (rsp0_valid || rsp1_valid || mul_start) seen = 1'b1;
    end
    m_never = 1'b0;
    checks++;
    if (seen) $display("FAIL midrun_no_response: activity seen %b expected 0", seen);
    else passed++;
    run_op(1'b1, 1'b1, 8'd4, 8'd4, 8'd8, 8'd8, 3, 1'b0, 1'b0, 0);
    checks++;
    if (o_win !== 0 || o_prod !== 16'd16) $display("FAIL post_reset_priority: win %0d prod %0d expected 0 16", o_win, o_prod);
    else passed++;
    ptr = 1 - o_win;
  endtask

  task automatic test_random();
    bit v0, v1, nd, st;
    logic [7:0] a0, b0, a1, b1;
    int lat, bp, ew, elat;
    logic [15:0] ep;
    for (int i = 0; i < 16; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
      lat = $urandom_range(1, 20);
      bp = $urandom_range(0, 3);
      nd = ($urandom_range(0, 7) == 0);
      st = 1'($urandom_range(0, 1));
      ew = predict(v0, v1);
      ep = nd ? 16'd0 : ((ew == 1) ? 16'(a1) * 16'(b1) : 16'(a0) * 16'(b0));
      elat = nd ? T + 2 : lat + 3;
      run_op(v0, v1, a0, b0, a1, b1, lat, nd, st, bp);
      ptr = 1 - ew;
      m_never = 1'b0;
      checks++;
      if (o_win !== ew || o_ch !== ew) $display("FAIL rand_grant_%0d: win %0d ch %0d expected %0d", i, o_win, o_ch, ew);
      else passed++;
      checks++;
      if (o_prod !== ep || o_err !== nd) $display("FAIL rand_result_%0d: got %h err %b expected %h err %b", i, o_prod, o_err, ep, nd);
      else passed++;
      checks++;
      if (o_lat !== elat) $display("FAIL rand_latency_%0d: got %0d expected %0d", i, o_lat, elat);
      else passed++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_stale_done();
    test_timeout();
    test_back_pressure();
    test_extremes_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
